// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl
//   Multi-cycle adder sequencer. Evaluates one 4-bit carry-lookahead group
//   per clock, least-significant nibble first, and registers the group carry
//   between cycles. The operand side and the result side both use a
//   valid/ready handshake.
//
//   Optional feature macro: CLA_SUB_EN
//     defined   : sub=1 at accept computes ain - bin (B inverted, carry-in 1)
//     undefined : sub is ignored; always ain + bin + cin0
//
//   Ports
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   operands valid            in_ready   block can accept operands
//     ain, bin   WIDTH-bit operands        cin0       carry into bit 0
//     sub        subtract request
//     out_valid  result valid              out_ready  sink accepts the result
//     sum        WIDTH-bit result          cout       carry out of bit WIDTH-1
//     ovf        signed overflow (carry into MSB xor cout)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one lookahead group per cycle, nibble k = 0 .. N-1
//   DONE  | result held with out_valid=1 until out_ready
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  // keep the counter at least one bit wide so WIDTH=4 still elaborates
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // effective B operand and carry-in, decided at accept time
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef CLA_SUB_EN
  always_comb begin
    b_eff = sub ? ~bin : bin;
    c_eff = sub ? 1'b1 : cin0;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;
  always_comb begin
    b_eff = bin;
    c_eff = cin0;
  end
`endif

  // one 4-bit lookahead group on nibble k
  logic [3:0] a_n, b_n, g, p, c, s_n;
  logic       g_grp, p_grp, c_out;

  always_comb begin
    a_n = a_q[{k_q, 2'b00} +: 4];
    b_n = b_q[{k_q, 2'b00} +: 4];
    g   = a_n & b_n;
    p   = a_n | b_n;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
    c_out = g_grp | (p_grp & c[0]);
    s_n   = a_n ^ b_n ^ c;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= ain;
            b_q     <= b_eff;
            carry_q <= c_eff;
            k_q     <= '0;
          end
        end
        RUN: begin
          sum_q[{k_q, 2'b00} +: 4] <= s_n;
          carry_q <= c_out;
          if (k_q == K_LAST) begin
            cout_q <= c_out;
            // c[3] of the top group is the carry into the MSB
            ovf_q  <= c[3] ^ c_out;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
